// File: rtl/elm_ctrl_pkg.sv
// Shared control encodings for the neuron-layer controllers.
// The state numbering is fixed so later layer controllers can reuse it.
package elm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } elm_state_e;

endpackage

// File: rtl/weight_read_sequencer.sv
// Steps one neuron's weight memory alongside its activation stream and
// delays the activation one cycle so it meets the weight read data.
//
// state | meaning
// IDLE  | waiting for element 0 of a vector, cnt = 0
// RUN   | accepting elements 1..numWeight-1, gaps allowed
// DRAIN | last pair on the MAC port, input stalled
// DONE  | done pulse, input stalled
module weight_read_sequencer #(
  parameter int numWeight    = 784,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [dataWidth-1:0]  in_data,
  output logic                  in_ready,
  output logic                  ren,
  output logic [addressWidth:0] raddr,
  input  logic [dataWidth-1:0]  wout,
  output logic                  mul_valid,
  output logic [dataWidth-1:0]  mul_x,
  output logic [dataWidth-1:0]  mul_w,
  output logic                  mul_last,
  output logic                  done
);
  import elm_ctrl_pkg::*;

  localparam int CW = addressWidth + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(numWeight - 1);

  elm_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 mul_valid_q, mul_last_q;
  logic [dataWidth-1:0] mul_x_q;
  logic                 accept, at_last;

  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign accept   = in_valid & in_ready;
  assign at_last  = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          if (numWeight == 1) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
            cnt_d   = CW'(1);
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (at_last) begin
            state_d = ST_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mul_valid_q <= 1'b0;
      mul_x_q     <= '0;
      mul_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mul_valid_q <= accept;
      mul_last_q  <= accept & at_last;
      if (accept) begin
        mul_x_q <= in_data;
      end
    end
  end

  // Read data arrives one cycle after ren, the same cycle mul_x_q updates.
  assign ren       = accept;
  assign raddr     = cnt_q;
  assign mul_valid = mul_valid_q;
  assign mul_x     = mul_x_q;
  assign mul_w     = wout;
  assign mul_last  = mul_last_q;
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_weight_read_sequencer.sv
// Scoreboard bench: a 4-weight instance exercised with gaps, back-to-back
// vectors and mid-vector reset, plus a single-weight instance.
module tb_weight_read_sequencer;

  localparam int NW = 4;
  localparam int AW = 10;
  localparam int DW = 16;

  typedef struct packed {
    logic [DW-1:0] x;
    logic [DW-1:0] w;
    logic          last;
  } pair_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          in_valid_a = 1'b0;
  logic [DW-1:0] in_data_a  = '0;
  logic          in_ready_a, ren_a, mul_valid_a, mul_last_a, done_a;
  logic [AW:0]   raddr_a;
  logic [DW-1:0] wout_a = '0;
  logic [DW-1:0] mul_x_a, mul_w_a;

  logic          in_valid_b = 1'b0;
  logic [DW-1:0] in_data_b  = '0;
  logic          in_ready_b, ren_b, mul_valid_b, mul_last_b, done_b;
  logic [AW:0]   raddr_b;
  logic [DW-1:0] wout_b = '0;
  logic [DW-1:0] mul_x_b, mul_w_b;

  weight_read_sequencer #(.numWeight(NW), .addressWidth(AW), .dataWidth(DW)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a), .in_data(in_data_a), .in_ready(in_ready_a),
    .ren(ren_a), .raddr(raddr_a), .wout(wout_a),
    .mul_valid(mul_valid_a), .mul_x(mul_x_a), .mul_w(mul_w_a),
    .mul_last(mul_last_a), .done(done_a)
  );

  weight_read_sequencer #(.numWeight(1), .addressWidth(AW), .dataWidth(DW)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
    .ren(ren_b), .raddr(raddr_b), .wout(wout_b),
    .mul_valid(mul_valid_b), .mul_x(mul_x_b), .mul_w(mul_w_b),
    .mul_last(mul_last_b), .done(done_b)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem_a [NW];
  initial begin
    mem_a[0] = 16'd10; mem_a[1] = 16'd20; mem_a[2] = 16'd30; mem_a[3] = 16'd40;
  end

  always @(posedge clk) begin
    if (ren_a) wout_a <= mem_a[raddr_a[1:0]];
    if (ren_b) wout_b <= 16'd5;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  pair_t         sb[$];
  int            idx      = 0;
  logic [1:0]    dd       = 2'b00;
  logic          prev_acc = 1'b0;
  logic          last_acc = 1'b0;
  logic [DW-1:0] last_x   = '0;
  logic [DW-1:0] xs [NW];
  initial begin
    xs[0] = 16'd1; xs[1] = 16'd2; xs[2] = 16'd3; xs[3] = 16'd4;
  end

  // One cycle on instance A: drive, sample at negedge, advance to posedge+1.
  task automatic step(input logic v, input logic [DW-1:0] x);
    pair_t e;
    logic  exp_ready, acc, la;
    in_valid_a = v;
    in_data_a  = x;
    @(negedge clk);
    chk("mul_valid", mul_valid_a, prev_acc);
    if (prev_acc) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 0, 1);
      end else begin
        e = sb.pop_front();
        chk("mul_x", mul_x_a, e.x);
        chk("mul_w", mul_w_a, e.w);
        chk("mul_last", mul_last_a, e.last);
      end
    end else begin
      chk("mul_last_idle", mul_last_a, 0);
      chk("mul_x_hold", mul_x_a, last_x);
    end
    exp_ready = !(dd[0] | dd[1]);
    chk("in_ready", in_ready_a, exp_ready);
    chk("done", done_a, dd[1]);
    chk("raddr", raddr_a, idx);
    acc = v & exp_ready;
    chk("ren", ren_a, acc);
    la = 1'b0;
    if (acc) begin
      e.x = x; e.w = mem_a[idx]; e.last = (idx == NW - 1);
      sb.push_back(e);
      last_x = x;
      if (idx == NW - 1) begin
        la  = 1'b1;
        idx = 0;
      end else begin
        idx++;
      end
    end
    dd       = {dd[0], la};
    prev_acc = acc;
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  // Sends xs[0..NW-1], holding in_valid until each is taken.
  task automatic send_vec(input int gap_after, input int gap_len, input int exp_tries0);
    for (int i = 0; i < NW; i++) begin
      int tries = 0;
      last_acc = 1'b0;
      while (!last_acc && tries < 8) begin
        step(1'b1, xs[i]);
        tries++;
      end
      if (!last_acc) chk("accept_timeout", 0, 1);
      if (i == 0 && exp_tries0 > 0) chk("b2b_stall_cycles", tries, exp_tries0);
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) step(1'b0, '0);
      end
    end
  endtask

  initial begin
    pair_t e;
    #3;
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_ren", ren_a, 0);
    chk("rst_raddr", raddr_a, 0);
    chk("rst_mul_valid", mul_valid_a, 0);
    chk("rst_mul_x", mul_x_a, 0);
    chk("rst_mul_last", mul_last_a, 0);
    chk("rst_done", done_a, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send_vec(-1, 0, 0);
    send_vec(-1, 0, 3);
    for (int i = 0; i < 3; i++) step(1'b0, '0);
    send_vec(1, 2, 0);
    for (int i = 0; i < 3; i++) step(1'b0, '0);

    // Abort a vector after two accepts; reset must act before any clock edge.
    step(1'b1, xs[0]);
    step(1'b1, xs[1]);
    in_valid_a = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_mul_valid", mul_valid_a, 0);
    chk("arst_mul_x", mul_x_a, 0);
    chk("arst_mul_last", mul_last_a, 0);
    chk("arst_raddr", raddr_a, 0);
    chk("arst_in_ready", in_ready_a, 1);
    chk("arst_done", done_a, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    idx = 0; dd = 2'b00; prev_acc = 1'b0; last_x = '0;
    for (int i = 0; i < 2; i++) step(1'b0, '0);
    send_vec(-1, 0, 0);
    for (int i = 0; i < 3; i++) step(1'b0, '0);
    chk("sb_drained", sb.size(), 0);

    in_valid_b = 1'b1;
    in_data_b  = 16'd7;
    @(negedge clk);
    chk("b_in_ready0", in_ready_b, 1);
    chk("b_ren", ren_b, 1);
    chk("b_raddr0", raddr_b, 0);
    e.x = 16'd7; e.w = 16'd5; e.last = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    @(negedge clk);
    chk("b_mul_valid", mul_valid_b, 1);
    e = sb.pop_front();
    chk("b_mul_x", mul_x_b, e.x);
    chk("b_mul_w", mul_w_b, e.w);
    chk("b_mul_last", mul_last_b, e.last);
    chk("b_in_ready1", in_ready_b, 0);
    chk("b_raddr1", raddr_b, 0);
    chk("b_done1", done_b, 0);
    @(negedge clk);
    chk("b_done2", done_b, 1);
    chk("b_mul_valid2", mul_valid_b, 0);
    chk("b_mul_last2", mul_last_b, 0);
    chk("b_raddr2", raddr_b, 0);
    chk("b_in_ready2", in_ready_b, 0);
    @(negedge clk);
    chk("b_in_ready3", in_ready_b, 1);
    chk("b_done3", done_b, 0);
    chk("b_raddr3", raddr_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_read_sequencer.md
# weight_read_sequencer

Sequences one neuron's weight memory in lockstep with its input-activation stream. It issues `ren`/`raddr` for each accepted input and compensates for the memory's 1-cycle read latency by delaying the input to match. It then presents aligned (x, w) pairs with valid/last flags to the neuron MAC, and pulses `done` when a full vector of `numWeight` products has been delivered. One instance sits between each neuron's input port and its weight memory.

## Interface
Parameters:
- `numWeight`, 784: weights per neuron and reads per transaction; 1 ≤ numWeight ≤ 2**addressWidth.
- `addressWidth`, 10: weight memory depth exponent.
- `dataWidth`, 16: activation/weight word width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input activation present.
- `in_data`  in  dataWidth  input activation.
- `in_ready`  out  1  sequencer accepts input this cycle.
- `ren`  out  1  weight memory read enable.
- `raddr`  out  addressWidth+1  weight memory read address.
- `wout`  in  dataWidth  weight memory read data, valid 1 cycle after `ren`.
- `mul_valid`  out  1  aligned pair valid.
- `mul_x`  out  dataWidth  delayed activation.
- `mul_w`  out  dataWidth  weight; combinational pass-through of `wout`.
- `mul_last`  out  1  final pair of the vector.
- `done`  out  1  one-cycle pulse, vector complete.

## Operation
- Accept = `in_valid & in_ready`. `ren` = accept, combinational. `raddr` = `cnt`, a registered counter of addressWidth+1 bits.
- States:
  - IDLE: `cnt`=0, `in_ready`=1. On accept: go to DRAIN if numWeight==1, else go to RUN with `cnt`=1.
  - RUN: `in_ready`=1. On accept: if `cnt`==numWeight-1, go to DRAIN with `cnt`=0; else `cnt`+1. With no accept, hold state and `cnt` (gaps allowed).
  - DRAIN: `in_ready`=0, `ren`=0. Unconditionally go to DONE.
  - DONE: `in_ready`=0, `done`=1. Unconditionally go to IDLE.
- Registered each cycle:
  - `mul_valid` <= accept.
  - `mul_x` <= `in_data` on accept; otherwise hold.
  - `mul_last` <= accept & (`cnt`==numWeight-1).
- `in_valid` in DRAIN/DONE is not consumed. The upstream holds it, and the data is accepted in the following IDLE as element 0 of the next vector.
- Counter never exceeds numWeight-1. Addresses ≥ numWeight are never issued.

## Timing
- Reset values: state IDLE, `cnt` 0, `raddr` 0, `ren` 0, `in_ready` 1, `mul_valid` 0, `mul_x` 0, `mul_last` 0, `done` 0. `mul_w` follows `wout` and is meaningful only while `mul_valid`=1.
- Latency: accept in cycle N → `mul_valid`/`mul_x`/`mul_w` in cycle N+1.
- Last pair: the last accept lands in cycle L. Then `mul_last` is in L+1 (DRAIN), `done` in L+2 (DONE), and `in_ready` is back to 1 in L+3.
- Minimum vector period: numWeight+2 cycles with continuous `in_valid`.
- Reset mid-operation: all registers return to reset values immediately. Any partial vector is discarded, with no `mul_last` and no `done`. The next accept reads address 0.
- `mul_last` is asserted only together with `mul_valid`.

## Structure
- Shared package `elm_ctrl_pkg`: 2-bit state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3). Later layer controllers reuse the same encoding.
- No sub-module. The block is the FSM, the counter and one alignment register stage, in a single module.

## Test plan
- numWeight=4, memory [0..3]=10,20,30,40, continuous x=1,2,3,4 → `raddr` 0,1,2,3. Pairs (1,10),(2,20),(3,30),(4,40) on consecutive cycles. `mul_last` with (4,40). `done` the next cycle.
- Same vector with `in_valid` low for 2 cycles between x=2 and x=3 → `raddr` holds 2 and `mul_valid` is low for 2 cycles. Pairs are unchanged and `done` is 2 cycles later than in the continuous case.
- Back-to-back vectors with `in_valid` held high → `in_ready` low for exactly 2 cycles (DRAIN, DONE). The second vector starts at `raddr` 0 and repeats the same pairs.
- `rst` asserted after 2 accepts → outputs return to reset values without waiting for a clock edge. No `done`. The next vector reads from address 0 and completes normally.
- numWeight=1, single x=7 with memory[0]=5 → pair (7,5) with `mul_valid` and `mul_last`. `done` the next cycle, and `cnt` never leaves 0.
